// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and width helpers.
package pll_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_seq_sync_2ff.sv
// Two-flop bit synchronizer, asynchronously cleared to 0.
module sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL RST/PWRDWN, qualifies LOCKED, and releases downstream domain resets in order,
// with bounded retry on lock timeout or lock loss.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT       = 65535,
    parameter int unsigned LOCK_STABLE_CYCLES = 256,
    parameter int unsigned RELEASE_GAP        = 16,
    parameter int unsigned NUM_DOMAINS        = 2,
    parameter int unsigned MAX_RETRIES        = 3,
    localparam int unsigned RETRY_W = (clog2(MAX_RETRIES + 1) > 0) ? clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   pll_locked,
    input  logic                   soft_reset_req,
    output logic                   pll_rst,
    output logic                   pll_pwrdwn,
    output logic [NUM_DOMAINS-1:0] domain_reset_n,
    output logic                   ready,
    output logic                   error,
    output logic [RETRY_W-1:0]     retry_count,
    output logic [STATE_W-1:0]     state
);

    localparam int unsigned CNT_MAX = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                           max2(LOCK_STABLE_CYCLES, RELEASE_GAP));
    localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first saw lock counts toward the stable window.
    localparam logic [CNT_W-1:0]   STAB_LAST    = CNT_W'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   pwrdwn_q, pwrdwn_d;
    logic                   ready_q, ready_d;
    logic                   error_q, error_d;
    logic                   locked_s;
    logic                   fail;

    sync_2ff u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_locked),
        .q      (locked_s)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_RESET_PLL;
            cnt_q     <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            dom_q     <= '0;
            pll_rst_q <= 1'b1;
            pwrdwn_q  <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            dom_q     <= dom_d;
            pll_rst_q <= pll_rst_d;
            pwrdwn_q  <= pwrdwn_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

    // Next state and counters; lock checks precede timeout/step decisions so lock events win.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        retry_d = retry_q;
        fail    = 1'b0;

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = (LOCK_STABLE_CYCLES == 1) ? ST_RELEASE : ST_STABILIZE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    fail = 1'b1;
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) begin
                    fail = 1'b1;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (!locked_s) begin
                    fail = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = ST_RESET_PLL;
                end
            end
            ST_FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        if (fail) begin
            cnt_d = '0;
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = ST_RESET_PLL;
            end else begin
                state_d = ST_FAULT;
            end
        end

        if (soft_reset_req) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            idx_d   = '0;
            retry_d = '0;
        end
    end

    // Output values registered alongside the state they belong to.
    always_comb begin
        pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
        pwrdwn_d  = (state_d == ST_FAULT);
        error_d   = (state_d == ST_FAULT);
        ready_d   = (state_d == ST_RUN);
        dom_d     = '0;
        if ((state_d == ST_RELEASE) || (state_d == ST_RUN)) begin
            dom_d = dom_q;
            if ((state_q == ST_RELEASE) && (cnt_q == GAP_LAST)) begin
                for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        dom_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign pll_rst        = pll_rst_q;
    assign pll_pwrdwn     = pwrdwn_q;
    assign domain_reset_n = dom_q;
    assign ready          = ready_q;
    assign error          = error_q;
    assign retry_count    = retry_q;
    assign state          = state_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences a PLLE2_BASE instance. Pulses its RST, waits for and qualifies LOCKED, then releases downstream domain resets one at a time in a fixed order.
- Detects lock timeout and lock loss, with bounded automatic retry. Parks the PLL powered down in a fault state.
- Runs on a free-running board clock (IBUF path), never on a PLL output. Sits between the PLL primitive and the SoC reset tree.

Parameters:
- PLL_RST_CYCLES, 16: clk cycles pll_rst is held high per attempt (min 1).
- LOCK_TIMEOUT, 65535: clk cycles allowed in WAIT_LOCK before the attempt fails (min 2).
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before release (min 1).
- RELEASE_GAP, 16: clk cycles between successive domain reset releases (min 1).
- NUM_DOMAINS, 2: number of downstream reset outputs (min 1).
- MAX_RETRIES, 3: failed attempts tolerated before FAULT (min 0).

Ports:
- clk  input  1  free-running reference clock
- resetn  input  1  asynchronous active-low reset
- pll_locked  input  1  PLL LOCKED; asynchronous to clk
- soft_reset_req  input  1  synchronous single-cycle request to restart the sequence
- pll_rst  output  1  to PLL RST, active-high
- pll_pwrdwn  output  1  to PLL PWRDWN
- domain_reset_n  output  NUM_DOMAINS  active-low domain resets; bit 0 released first
- ready  output  1  all domains released, PLL locked
- error  output  1  sequencer in FAULT
- retry_count  output  clog2(MAX_RETRIES+1)  failed attempts since last RUN or soft reset
- state  output  3  debug encoding of the current state

Behaviour:
- Clock and reset: single clock. Reset is asynchronous, active-low (resetn); all flops are reset by it.
- Reset values:
  - state=RESET_PLL, pll_rst=1, pll_pwrdwn=0, domain_reset_n=all 0.
  - ready=0, error=0, retry_count=0, all counters 0.
  - Synchronizer flops 0.
- Lock synchronizer: pll_locked passes through 2 flops; all logic uses locked_s. This adds 2 cycles of latency.
- State encoding: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RELEASE=3, RUN=4, FAULT=5. All outputs are registered.
- RESET_PLL:
  - pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
  - pll_rst=0 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - Counter increments each cycle.
  - locked_s=1: go to STABILIZE, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 without lock: failed attempt.
- STABILIZE:
  - locked_s must stay 1 for LOCK_STABLE_CYCLES cycles, counting the WAIT_LOCK cycle that first saw lock.
  - Any 0: failed attempt.
  - On completion go to RELEASE with gap counter 0, index 0.
- RELEASE:
  - Every RELEASE_GAP cycles, set domain_reset_n[index] high and increment index.
  - When the last bit is set, go to RUN in the same cycle. ready=1 is registered together with the last bit.
  - locked_s=0 in RELEASE: failed attempt.
- Release timing: if T is the first cycle with locked_s=1, domain_reset_n[k] rises at T + LOCK_STABLE_CYCLES + (k+1)*RELEASE_GAP.
- Failed attempt:
  - All domain_reset_n go to 0 and ready=0 on the next edge.
  - If retry_count < MAX_RETRIES: retry_count increments and go to RESET_PLL.
  - Otherwise go to FAULT; retry_count is not incremented past MAX_RETRIES.
- RUN:
  - retry_count cleared on entry.
  - locked_s=0: go to RESET_PLL with domains reasserted and ready=0. This is not counted as a failed attempt.
- FAULT: pll_rst=1, pll_pwrdwn=1, error=1, domain_reset_n=0, ready=0. Exit only via soft_reset_req or resetn.
- soft_reset_req:
  - Highest priority, from any state (including mid-RELEASE): next state RESET_PLL.
  - Domains reasserted, retry_count=0, error=0, pll_pwrdwn=0, counters cleared.
  - Asserted while already in RESET_PLL: restarts the pll_rst count.
- Simultaneous events:
  - Lock loss together with the final release step: lock loss wins and domains stay in reset.
  - Timeout and lock arriving in the same cycle: lock wins.
- Counter width: clog2(max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES, RELEASE_GAP)+1). Index width: clog2(NUM_DOMAINS+1).

Decomposition:
- Package pll_seq_pkg: state encoding constants, state width (3), and a clog2 helper function.
- One sub-module, sync_2ff: 2-flop bit synchronizer with async active-low reset to 0. It is instantiated for pll_locked.

Test Plan:
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, RELEASE_GAP=3, NUM_DOMAINS=2, MAX_RETRIES=2.
1. Nominal bring-up: resetn released, pll_locked raised 10 cycles later.
   -> pll_rst high exactly 4 cycles. domain_reset_n[0] rises at T+11, [1] and ready rise at T+14. retry_count=0.
2. No lock ever.
   -> 3 attempts, each 4 cycles pll_rst plus 20 cycles wait. retry_count goes 1, 2. Then FAULT: error=1, pll_pwrdwn=1, pll_rst=1, state=5.
3. Lock glitch: pll_locked high 5 cycles then low during STABILIZE.
   -> retry_count=1, RESET_PLL re-entered, domains never released. A later steady lock reaches RUN and retry_count clears to 0.
4. Lock loss in RUN.
   -> Within 3 cycles of the pll_locked fall, domain_reset_n=0 and ready=0. state=RESET_PLL, retry_count stays 0.
5. soft_reset_req in FAULT, and again mid-RELEASE after domain 0 is released.
   -> Next cycle: state=0, error=0, pll_pwrdwn=0, domain_reset_n=00, pll_rst high 4 cycles.
6. resetn asserted mid-RELEASE with no clock edge.
   -> Outputs take reset values asynchronously: domain_reset_n=00, pll_rst=1.
